// File: rtl/demux1to8_sched_if.sv
// Producer/consumer bundle for the round-robin 1-to-8 demux dispatcher.
// slave = dispatcher side, master = producer/consumer side.
interface demux1to8_sched_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [7:0]    chan_en;
    logic [7:0]    dst_ready;
    logic [7:0]    dst_valid;
    logic [DW-1:0] dst_data;
    logic [2:0]    sel;
    logic [15:0]   xfer_cnt;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_data,
        input  chan_en,
        input  dst_ready,
        output dst_valid,
        output dst_data,
        output sel,
        output xfer_cnt
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_data,
        output chan_en,
        output dst_ready,
        input  dst_valid,
        input  dst_data,
        input  sel,
        input  xfer_cnt
    );
endinterface

// File: rtl/demux1to8_sched.sv
// Round-robin dispatcher driving the select of a 1-to-8 demux; one-item holding buffer.
// Optional macro DEMUX_SCHED_SKIP_EN: work-conserving skip past a stalled channel.
module demux1to8_sched #(
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    demux1to8_sched_if.slave   bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OFFER = 1'b1;

    // First enabled channel searching cyclically from p+1, with p itself tried last.
    function automatic logic [2:0] f_next_en(input logic [2:0] p, input logic [7:0] en);
        logic [2:0] res;
        logic [2:0] cand;
        logic       found;
        res   = p;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cand = p + 3'(k);
            if (!found && en[cand]) begin
                res   = cand;
                found = 1'b1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // First channel strictly after p that is both enabled and ready; p when none.
    function automatic logic [2:0] f_next_rdy(input logic [2:0] p, input logic [7:0] en,
                                              input logic [7:0] rdy);
        logic [2:0] res;
        logic [2:0] cand;
        logic       found;
        res   = p;
        found = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            cand = p + 3'(k);
            if (!found && en[cand] && rdy[cand]) begin
                res   = cand;
                found = 1'b1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [0:0]    r_state;
    logic [DW-1:0] r_hold_data;
    logic [2:0]    r_sel;
    logic [7:0]    r_dst_valid;
    logic [15:0]   r_xfer_cnt;

    logic          w_hold_vld;
    logic          w_fire;
    logic          w_in_ready;
    logic          w_acc;
    logic [0:0]    w_next_state;
    logic [2:0]    w_next_sel;
    logic [DW-1:0] w_next_data;
    logic [7:0]    w_next_dst_valid;

    assign w_hold_vld = (r_state == ST_OFFER);
    assign w_fire     = w_hold_vld & bus.chan_en[r_sel] & bus.dst_ready[r_sel];
    // in_ready is deliberately combinational from dst_ready/chan_en to sustain full throughput.
    assign w_in_ready = ~w_hold_vld | w_fire;
    assign w_acc      = bus.in_valid & w_in_ready;

    // Holding-register state transitions.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    w_next_state = ST_OFFER;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (w_fire && !w_acc) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_OFFER;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Pointer update: a fire advances exactly once and takes priority over any re-search.
    always_comb begin
        w_next_sel = r_sel;
        if (w_fire) begin
            w_next_sel = f_next_en(r_sel, bus.chan_en);
        end else if (w_hold_vld && !bus.chan_en[r_sel]) begin
            w_next_sel = f_next_en(r_sel, bus.chan_en);
`ifdef DEMUX_SCHED_SKIP_EN
        end else if (w_hold_vld && !bus.dst_ready[r_sel]) begin
            w_next_sel = f_next_rdy(r_sel, bus.chan_en, bus.dst_ready);
`endif
        end else begin
            w_next_sel = r_sel;
        end
    end

    // Next payload and the one-hot valid that will accompany it.
    always_comb begin
        w_next_data      = r_hold_data;
        w_next_dst_valid = 8'h00;
        if (w_acc) begin
            w_next_data = bus.in_data;
        end else begin
            w_next_data = r_hold_data;
        end
        if (w_next_state == ST_OFFER) begin
            w_next_dst_valid = 8'h01 << w_next_sel;
        end else begin
            w_next_dst_valid = 8'h00;
        end
    end

    // State, pointer, payload and valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sel       <= 3'd0;
            r_hold_data <= '0;
            r_dst_valid <= 8'h00;
        end else begin
            r_state     <= w_next_state;
            r_sel       <= w_next_sel;
            r_hold_data <= w_next_data;
            r_dst_valid <= w_next_dst_valid;
        end
    end

    // Completed-transfer counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= 16'd0;
        end else if (w_fire) begin
            r_xfer_cnt <= r_xfer_cnt + 16'd1;
        end else begin
            r_xfer_cnt <= r_xfer_cnt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.dst_valid = r_dst_valid;
    assign bus.dst_data  = r_hold_data;
    assign bus.sel       = r_sel;
    assign bus.xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_demux1to8_sched.sv
// Directed self-checking bench for demux1to8_sched.
module tb_demux1to8_sched;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    demux1to8_sched_if #(.DW(8)) bus ();

    demux1to8_sched #(.DW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.chan_en   = 8'h00;
        bus.dst_ready = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.chan_en   = 8'hFF;
        bus.dst_ready = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.dst_valid !== 8'h00) begin n_err++; $display("FAIL rst_dst_valid got %h exp 00", bus.dst_valid); end
        n_cmp++; if (bus.dst_data !== 8'h00) begin n_err++; $display("FAIL rst_dst_data got %h exp 00", bus.dst_data); end
        n_cmp++; if (bus.sel !== 3'd0) begin n_err++; $display("FAIL rst_sel got %0d exp 0", bus.sel); end
        n_cmp++; if (bus.xfer_cnt !== 16'd0) begin n_err++; $display("FAIL rst_xfer_cnt got %0d exp 0", bus.xfer_cnt); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_v;
        do_reset();
        bus.chan_en   = 8'hFF;
        bus.dst_ready = 8'hFF;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h00;
        for (int k = 0; k < 10; k++) begin
            tick();
            bus.in_data = 8'(k + 1);
            if (k == 9) bus.in_valid = 1'b0;
            @(negedge clk);
            exp_v = 8'h01 << (k % 8);
            n_cmp++; if (bus.dst_valid !== exp_v) begin n_err++; $display("FAIL stream_valid[%0d] got %h exp %h", k, bus.dst_valid, exp_v); end
            n_cmp++; if (bus.dst_data !== 8'(k)) begin n_err++; $display("FAIL stream_data[%0d] got %h exp %h", k, bus.dst_data, 8'(k)); end
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d] got %b exp 1", k, bus.in_ready); end
        end
        tick();
        n_cmp++; if (bus.xfer_cnt !== 16'd10) begin n_err++; $display("FAIL stream_xfer_cnt got %0d exp 10", bus.xfer_cnt); end
        n_cmp++; if (bus.dst_valid !== 8'h00) begin n_err++; $display("FAIL stream_idle_valid got %h exp 00", bus.dst_valid); end
        n_cmp++; if (bus.sel !== 3'd2) begin n_err++; $display("FAIL stream_end_sel got %0d exp 2", bus.sel); end
    endtask

    task automatic test_sparse_enable();
        logic [7:0] exp_v [4];
        logic [2:0] exp_s [4];
        exp_v = '{8'h01, 8'h04, 8'h80, 8'h01};
        exp_s = '{3'd0, 3'd2, 3'd7, 3'd0};
        do_reset();
        bus.chan_en   = 8'b1000_0101;
        bus.dst_ready = 8'hFF;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hA0;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.in_data = 8'hA0 + 8'(k + 1);
            if (k == 3) bus.in_valid = 1'b0;
            @(negedge clk);
            n_cmp++; if (bus.dst_valid !== exp_v[k]) begin n_err++; $display("FAIL sparse_valid[%0d] got %h exp %h", k, bus.dst_valid, exp_v[k]); end
            n_cmp++; if (bus.sel !== exp_s[k]) begin n_err++; $display("FAIL sparse_sel[%0d] got %0d exp %0d", k, bus.sel, exp_s[k]); end
            n_cmp++; if (bus.dst_data !== 8'hA0 + 8'(k)) begin n_err++; $display("FAIL sparse_data[%0d] got %h exp %h", k, bus.dst_data, 8'hA0 + 8'(k)); end
        end
        tick();
        n_cmp++; if (bus.xfer_cnt !== 16'd4) begin n_err++; $display("FAIL sparse_xfer_cnt got %0d exp 4", bus.xfer_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.chan_en   = 8'hFF;
        bus.dst_ready = 8'hFE;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h55;
        tick();
        bus.in_valid = 1'b0;
`ifdef DEMUX_SCHED_SKIP_EN
        @(negedge clk);
        n_cmp++; if (bus.dst_valid !== 8'h01) begin n_err++; $display("FAIL skip_c1_valid got %h exp 01", bus.dst_valid); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL skip_c1_in_ready got %b exp 0", bus.in_ready); end
        tick();
        @(negedge clk);
        n_cmp++; if (bus.dst_valid !== 8'h02) begin n_err++; $display("FAIL skip_c2_valid got %h exp 02", bus.dst_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL skip_c2_in_ready got %b exp 1", bus.in_ready); end
        tick();
`else
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.dst_valid !== 8'h01) begin n_err++; $display("FAIL stall_valid[%0d] got %h exp 01", i, bus.dst_valid); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d] got %b exp 0", i, bus.in_ready); end
            n_cmp++; if (bus.dst_data !== 8'h55) begin n_err++; $display("FAIL stall_data[%0d] got %h exp 55", i, bus.dst_data); end
            tick();
        end
        bus.dst_ready = 8'hFF;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_in_ready got %b exp 1", bus.in_ready); end
        tick();
`endif
        n_cmp++; if (bus.xfer_cnt !== 16'd1) begin n_err++; $display("FAIL stall_xfer_cnt got %0d exp 1", bus.xfer_cnt); end
        n_cmp++; if (bus.dst_valid !== 8'h00) begin n_err++; $display("FAIL stall_idle_valid got %h exp 00", bus.dst_valid); end
    endtask

    task automatic test_all_disabled();
        do_reset();
        bus.chan_en   = 8'h00;
        bus.dst_ready = 8'hFF;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h77;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.dst_valid !== 8'h01) begin n_err++; $display("FAIL dis_valid[%0d] got %h exp 01", i, bus.dst_valid); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL dis_in_ready[%0d] got %b exp 0", i, bus.in_ready); end
            n_cmp++; if (bus.sel !== 3'd0) begin n_err++; $display("FAIL dis_sel[%0d] got %0d exp 0", i, bus.sel); end
            tick();
        end
        n_cmp++; if (bus.xfer_cnt !== 16'd0) begin n_err++; $display("FAIL dis_xfer_cnt got %0d exp 0", bus.xfer_cnt); end
        bus.chan_en = 8'h10;
        tick();
        n_cmp++; if (bus.sel !== 3'd4) begin n_err++; $display("FAIL dis_resel got %0d exp 4", bus.sel); end
        n_cmp++; if (bus.dst_valid !== 8'h10) begin n_err++; $display("FAIL dis_resel_valid got %h exp 10", bus.dst_valid); end
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL dis_fire_in_ready got %b exp 1", bus.in_ready); end
        tick();
        n_cmp++; if (bus.xfer_cnt !== 16'd1) begin n_err++; $display("FAIL dis_fire_xfer got %0d exp 1", bus.xfer_cnt); end
        n_cmp++; if (bus.dst_valid !== 8'h00) begin n_err++; $display("FAIL dis_fire_idle got %h exp 00", bus.dst_valid); end
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        bus.chan_en   = 8'h08;
        bus.dst_ready = 8'hFF;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h11;
        tick();
        bus.in_valid = 1'b0;
        tick();
        n_cmp++; if (bus.sel !== 3'd3) begin n_err++; $display("FAIL mid_sel_move got %0d exp 3", bus.sel); end
        tick();
        n_cmp++; if (bus.xfer_cnt !== 16'd1) begin n_err++; $display("FAIL mid_first_xfer got %0d exp 1", bus.xfer_cnt); end
        bus.dst_ready = 8'h00;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h22;
        tick();
        bus.in_valid = 1'b0;
        tick();
        n_cmp++; if (bus.dst_valid !== 8'h08) begin n_err++; $display("FAIL mid_held_valid got %h exp 08", bus.dst_valid); end
        n_cmp++; if (bus.dst_data !== 8'h22) begin n_err++; $display("FAIL mid_held_data got %h exp 22", bus.dst_data); end
        rst_n = 1'b0;
        #2;
        n_cmp++; if (bus.dst_valid !== 8'h00) begin n_err++; $display("FAIL mid_rst_valid got %h exp 00", bus.dst_valid); end
        n_cmp++; if (bus.sel !== 3'd0) begin n_err++; $display("FAIL mid_rst_sel got %0d exp 0", bus.sel); end
        n_cmp++; if (bus.xfer_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_xfer got %0d exp 0", bus.xfer_cnt); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_in_ready got %b exp 1", bus.in_ready); end
        tick();
        rst_n         = 1'b1;
        bus.chan_en   = 8'hFF;
        bus.dst_ready = 8'hFF;
        repeat (3) tick();
        n_cmp++; if (bus.xfer_cnt !== 16'd0) begin n_err++; $display("FAIL mid_post_xfer got %0d exp 0", bus.xfer_cnt); end
        n_cmp++; if (bus.dst_valid !== 8'h00) begin n_err++; $display("FAIL mid_post_valid got %h exp 00", bus.dst_valid); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        bus.chan_en   = 8'hFF;
        bus.dst_ready = 8'hFF;
        bus.in_valid  = 1'b1;
        for (int n = 0; n < 65536; n++) begin
            bus.in_data = 8'(n);
            tick();
        end
        n_cmp++; if (bus.xfer_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_pre got %h exp FFFF", bus.xfer_cnt); end
        bus.in_valid = 1'b0;
        tick();
        n_cmp++; if (bus.xfer_cnt !== 16'h0000) begin n_err++; $display("FAIL wrap_post got %h exp 0000", bus.xfer_cnt); end
        n_cmp++; if (bus.dst_valid !== 8'h00) begin n_err++; $display("FAIL wrap_idle got %h exp 00", bus.dst_valid); end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.chan_en   = 8'h00;
        bus.dst_ready = 8'h00;
        test_reset();
        test_back_to_back();
        test_sparse_enable();
        test_stall();
        test_all_disabled();
        test_reset_mid_offer();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
